uart_frame_ctrl: RTL and testbench
==================================

# uart_frame_ctrl

Frame-level controller that sits directly behind the UART receiver in the image-processing board interface. It consumes the receiver's byte stream (one `done` pulse per byte) and sequences the bytes into command frames. It writes payload bytes into a downstream parameter register file and reports each frame as valid or errored. A byte-gap timeout keeps a stalled or truncated frame from hanging the interface.

## Interface
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `MAX_LEN`, 16: maximum payload length in bytes; must be ≤ 2**ADDR_W.
- `ADDR_W`, 4: width of the payload write address.
- `TIMEOUT_CLKS`, 5000: idle clocks allowed between bytes inside a frame; must be ≤ 65535.

- `i_clk` in 1: system clock, the same clock as the UART receiver.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_rx_done` in 1: single-cycle byte-valid pulse from the receiver.
- `i_rx_data` in 8: received byte; valid while `i_rx_done`=1.
- `o_wr_en` out 1: one-cycle payload write strobe.
- `o_wr_addr` out ADDR_W: payload byte index, 0-based.
- `o_wr_data` out 8: payload byte.
- `o_frame_valid` out 1: one-cycle pulse when a frame passes its checksum.
- `o_frame_cmd` out 8: command byte of the last valid frame; held until the next valid frame.
- `o_frame_len` out 8: payload length of the last valid frame; held until the next valid frame.
- `o_frame_err` out 1: one-cycle pulse on any frame error.
- `o_err_code` out 2: cause of the last error (01 length, 10 checksum, 11 timeout); held until the next error.
- `o_busy` out 1: high whenever state ≠ IDLE.

## Operation
- Frame format: SYNC, CMD, LEN, LEN payload bytes, CHK.
  - CHK = XOR of CMD, LEN and all payload bytes.
  - SYNC is excluded from CHK.
- States and transitions. Every transition below happens only on a cycle with `i_rx_done`=1, except timeout.
  - IDLE:
    - Byte == SYNC_BYTE → GET_CMD.
    - Any other byte is discarded silently; no error is raised.
  - GET_CMD: latch cmd; chk ← byte → GET_LEN.
  - GET_LEN:
    - Byte > MAX_LEN → pulse error with code 01 → IDLE.
    - Byte == 0 → GET_CHK.
    - Otherwise latch len; idx ← 0; → GET_PAYLOAD.
    - In all cases chk ← chk ^ byte.
  - GET_PAYLOAD:
    - Issue a write with addr = idx and data = byte.
    - chk ^= byte.
    - If idx == len-1 → GET_CHK; otherwise idx++.
  - GET_CHK:
    - Byte == chk → pulse `o_frame_valid`; update `o_frame_cmd` and `o_frame_len` → IDLE.
    - Otherwise → pulse error with code 10 → IDLE.
- Timeout:
  - A 16-bit gap counter runs in every state except IDLE.
  - It clears on each `i_rx_done` and on entry to GET_CMD.
  - When it reaches TIMEOUT_CLKS-1 without a byte: pulse error with code 11 → IDLE.
- Payload writes are never retracted. Downstream commits only on `o_frame_valid`.
- A SYNC_BYTE value received mid-frame is treated as ordinary data; there is no resynchronisation.
- Simultaneous `i_rx_done` and timeout in the same cycle: the byte wins and no timeout is raised.
- `i_rx_done` held high for k cycles is consumed as k bytes. The receiver guarantees single-cycle pulses.

## Timing
- All outputs are registered.
- `i_rx_done` sampled at edge N → `o_wr_en`, `o_frame_valid` or `o_frame_err` high during cycle N+1, for exactly one cycle.
- `o_wr_addr` and `o_wr_data` are valid only while `o_wr_en`=1.
- The state change is visible on `o_busy` in cycle N+1.
- A timeout detected at edge T → `o_frame_err` high in cycle T+1, and `o_busy` low in cycle T+1.
- Reset, asynchronous and possible mid-frame:
  - State ← IDLE, and all counters are zeroed.
  - All outputs ← 0: `o_wr_en`, `o_wr_addr`, `o_wr_data`, `o_frame_valid`, `o_frame_cmd`, `o_frame_len`, `o_frame_err`, `o_err_code`, `o_busy`.
  - After reset deassertion, the first byte is evaluated in IDLE.
- Back-to-back frames: a SYNC byte may arrive on the cycle immediately after CHK and is accepted.

## Test plan
- Bytes A5,03,02,11,22,32 → writes (0,11),(1,22); `o_frame_valid` pulse; cmd=03; len=02; no error.
- Bytes A5,07,00,07 (zero length) → no writes; `o_frame_valid` pulse; cmd=07; len=00.
- Bytes A5,03,02,11,22,33 → two writes; `o_frame_err` pulse with code 10; no valid pulse; cmd and len keep their previous values.
- Bytes A5,01,11 (len 17 > MAX_LEN) → `o_frame_err` code 01 one cycle after the LEN byte; no writes; IDLE. A following bytes 55,A5 → only A5 starts a frame.
- Bytes A5,01,02,AA then silence → err code 11 exactly TIMEOUT_CLKS cycles after the AA byte; `o_busy` drops. Repeat with a byte arriving on the timeout cycle → no error.
- Assert `i_rst` mid-payload → all outputs 0 and IDLE immediately. Deassert, then send a full frame → valid frame reported normally.

Source files
------------

// File: rtl/uart_frame_ctrl_if.sv
// Byte-stream input and frame-result output bundle for uart_frame_ctrl.
// The slave modport is the controller side; the master modport drives bytes and observes results.
interface uart_frame_ctrl_if #(
   parameter int unsigned ADDR_W = 4
);
   logic              i_rx_done;
   logic [7:0]        i_rx_data;
   logic              o_wr_en;
   logic [ADDR_W-1:0] o_wr_addr;
   logic [7:0]        o_wr_data;
   logic              o_frame_valid;
   logic [7:0]        o_frame_cmd;
   logic [7:0]        o_frame_len;
   logic              o_frame_err;
   logic [1:0]        o_err_code;
   logic              o_busy;

   modport master (
      output i_rx_done, i_rx_data,
      input  o_wr_en, o_wr_addr, o_wr_data, o_frame_valid, o_frame_cmd, o_frame_len,
             o_frame_err, o_err_code, o_busy
   );

   modport slave (
      input  i_rx_done, i_rx_data,
      output o_wr_en, o_wr_addr, o_wr_data, o_frame_valid, o_frame_cmd, o_frame_len,
             o_frame_err, o_err_code, o_busy
   );
endinterface

// File: rtl/uart_frame_ctrl.sv
// Sequences UART bytes into SYNC/CMD/LEN/payload/CHK frames, writes payload bytes out,
// and reports each frame as valid or errored, with a byte-gap timeout inside a frame.
module uart_frame_ctrl #(
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter int unsigned MAX_LEN      = 16,
   parameter int unsigned ADDR_W       = 4,
   parameter int unsigned TIMEOUT_CLKS = 5000
) (
   input logic              i_clk,
   input logic              i_rst,
   uart_frame_ctrl_if.slave bus_io
);
   typedef enum logic [2:0] {
      StIdle,
      StGetCmd,
      StGetLen,
      StGetPayload,
      StGetChk
   } state_e;

   localparam logic [15:0] GapLast = 16'(TIMEOUT_CLKS - 1);

   state_e            state_q;
   logic [7:0]        cmd_q;
   logic [7:0]        len_q;
   logic [7:0]        chk_q;
   logic [ADDR_W-1:0] idx_q;
   logic [15:0]       gap_q;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [7:0]        wr_data_q;
   logic              frame_valid_q;
   logic [7:0]        frame_cmd_q;
   logic [7:0]        frame_len_q;
   logic              frame_err_q;
   logic [1:0]        err_code_q;
   logic [7:0]        rx_byte;

   assign rx_byte = bus_io.i_rx_data;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q       <= StIdle;
         cmd_q         <= '0;
         len_q         <= '0;
         chk_q         <= '0;
         idx_q         <= '0;
         gap_q         <= '0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         frame_valid_q <= 1'b0;
         frame_cmd_q   <= '0;
         frame_len_q   <= '0;
         frame_err_q   <= 1'b0;
         err_code_q    <= '0;
      end else begin
         wr_en_q       <= 1'b0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;

         if (state_q == StIdle || bus_io.i_rx_done) gap_q <= '0;
         else                                      gap_q <= gap_q + 16'd1;

         // A byte arriving on the timeout cycle takes priority over the timeout.
         if (bus_io.i_rx_done) begin
            unique case (state_q)
               StIdle: begin
                  if (rx_byte == SYNC_BYTE) state_q <= StGetCmd;
               end
               StGetCmd: begin
                  cmd_q   <= rx_byte;
                  chk_q   <= rx_byte;
                  state_q <= StGetLen;
               end
               StGetLen: begin
                  chk_q <= chk_q ^ rx_byte;
                  len_q <= rx_byte;
                  idx_q <= '0;
                  if (32'(rx_byte) > MAX_LEN) begin
                     frame_err_q <= 1'b1;
                     err_code_q  <= 2'b01;
                     state_q     <= StIdle;
                  end else if (rx_byte == 8'd0) begin
                     state_q <= StGetChk;
                  end else begin
                     state_q <= StGetPayload;
                  end
               end
               StGetPayload: begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= idx_q;
                  wr_data_q <= rx_byte;
                  chk_q     <= chk_q ^ rx_byte;
                  if (8'(idx_q) == len_q - 8'd1) state_q <= StGetChk;
                  else                           idx_q   <= idx_q + 1'b1;
               end
               StGetChk: begin
                  if (rx_byte == chk_q) begin
                     frame_valid_q <= 1'b1;
                     frame_cmd_q   <= cmd_q;
                     frame_len_q   <= len_q;
                  end else begin
                     frame_err_q <= 1'b1;
                     err_code_q  <= 2'b10;
                  end
                  state_q <= StIdle;
               end
               default: state_q <= StIdle;
            endcase
         end else if (state_q != StIdle && gap_q == GapLast) begin
            frame_err_q <= 1'b1;
            err_code_q  <= 2'b11;
            state_q     <= StIdle;
         end
      end
   end

   assign bus_io.o_wr_en       = wr_en_q;
   assign bus_io.o_wr_addr     = wr_addr_q;
   assign bus_io.o_wr_data     = wr_data_q;
   assign bus_io.o_frame_valid = frame_valid_q;
   assign bus_io.o_frame_cmd   = frame_cmd_q;
   assign bus_io.o_frame_len   = frame_len_q;
   assign bus_io.o_frame_err   = frame_err_q;
   assign bus_io.o_err_code    = err_code_q;
   assign bus_io.o_busy        = (state_q != StIdle);
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Scoreboard bench for uart_frame_ctrl: frame builders push the expected writes/results,
// an independent monitor pops and compares whenever the DUT pulses an output.
module tb_uart_frame_ctrl;
   localparam int unsigned ADDR_W  = 4;
   localparam int unsigned MAX_LEN = 16;
   localparam int unsigned TO      = 64;
   localparam logic [7:0]  SYNC    = 8'hA5;

   localparam int EvWr  = 0;
   localparam int EvOk  = 1;
   localparam int EvErr = 2;

   typedef struct {
      int     kind;
      int     a;
      int     b;
      longint cyc;
   } ev_t;

   logic   clk = 1'b0;
   logic   rst = 1'b0;
   longint cyc = 0;
   longint last_cyc = 0;
   int     n_chk = 0;
   int     n_pass = 0;
   ev_t    sb[$];
   int     mon_cmd = 0;
   int     mon_len = 0;
   int     mon_code = 0;
   logic [7:0] noq[$];

   uart_frame_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   uart_frame_ctrl #(
      .SYNC_BYTE   (SYNC),
      .MAX_LEN     (MAX_LEN),
      .ADDR_W      (ADDR_W),
      .TIMEOUT_CLKS(TO)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus_io(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string name, longint act, longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                    name, act, act, exp, exp, cyc);
   endfunction

   function automatic ev_t mk(int kind, int a, int b);
      ev_t e;
      e.kind = kind;
      e.a    = a;
      e.b    = b;
      e.cyc  = 0;
      return e;
   endfunction

   function automatic int pick_gap(int g);
      if (g >= 0) return g;
      return ($urandom_range(0, 15) == 0) ? int'(TO) - 1 : int'($urandom_range(0, 3));
   endfunction

   function automatic void check_zero_outputs(string pfx);
      check({pfx, "_wr_en"},       bus.o_wr_en, 0);
      check({pfx, "_wr_addr"},     bus.o_wr_addr, 0);
      check({pfx, "_wr_data"},     bus.o_wr_data, 0);
      check({pfx, "_frame_valid"}, bus.o_frame_valid, 0);
      check({pfx, "_frame_cmd"},   bus.o_frame_cmd, 0);
      check({pfx, "_frame_len"},   bus.o_frame_len, 0);
      check({pfx, "_frame_err"},   bus.o_frame_err, 0);
      check({pfx, "_err_code"},    bus.o_err_code, 0);
      check({pfx, "_busy"},        bus.o_busy, 0);
   endfunction

   // Monitor: every output pulse must match the oldest outstanding expectation.
   initial forever begin
      @(negedge clk);
      if (!rst && (bus.o_wr_en || bus.o_frame_valid || bus.o_frame_err)) begin
         ev_t e;
         int  kind;
         kind = bus.o_wr_en ? EvWr : (bus.o_frame_valid ? EvOk : EvErr);
         check("single_pulse", int'(bus.o_wr_en) + int'(bus.o_frame_valid)
               + int'(bus.o_frame_err), 1);
         if (sb.size() == 0) begin
            check("unexpected_output", kind, -1);
         end else begin
            e = sb.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.cyc);
            case (e.kind)
               EvWr: begin
                  check("wr_addr", bus.o_wr_addr, e.a);
                  check("wr_data", bus.o_wr_data, e.b);
                  check("busy_in_payload", bus.o_busy, 1);
               end
               EvOk: begin
                  mon_cmd = e.a;
                  mon_len = e.b;
                  check("busy_after_frame", bus.o_busy, 0);
               end
               default: begin
                  mon_code = e.a;
                  check("busy_after_err", bus.o_busy, 0);
               end
            endcase
            check("frame_cmd", bus.o_frame_cmd, mon_cmd);
            check("frame_len", bus.o_frame_len, mon_len);
            check("err_code", bus.o_err_code, mon_code);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap, input bit has_ev, input ev_t e);
      repeat (gap) @(negedge clk);
      bus.i_rx_done = 1'b1;
      bus.i_rx_data = b;
      last_cyc = cyc;
      if (has_ev) begin
         e.cyc = cyc + 1;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.i_rx_done = 1'b0;
      bus.i_rx_data = 8'($urandom);
   endtask

   // stop >= 0 sends only that many bytes after SYNC, then stays silent into a timeout.
   task automatic send_frame(input logic [7:0] cmd, input int len, input logic [7:0] pl_in[$],
                             input int stop, input logic [7:0] chk_flip, input int gap);
      logic [7:0] seq[$];
      logic [7:0] chk;
      logic [7:0] p;
      ev_t        e;
      ev_t        none;
      bit         has;
      none = mk(EvWr, 0, 0);
      chk  = cmd ^ 8'(len);
      seq.push_back(cmd);
      seq.push_back(8'(len));
      if (len <= int'(MAX_LEN)) begin
         for (int i = 0; i < len; i++) begin
            p = (pl_in.size() == len) ? pl_in[i] : 8'($urandom);
            seq.push_back(p);
            chk ^= p;
         end
         seq.push_back(chk ^ chk_flip);
      end
      send_byte(SYNC, pick_gap(gap), 1'b0, none);
      for (int i = 0; i < seq.size(); i++) begin
         if (stop >= 0 && i >= stop) break;
         has = 1'b1;
         e   = none;
         if (i == 1 && len > int'(MAX_LEN))   e = mk(EvErr, 1, 0);
         else if (i >= 2 && i < 2 + len)      e = mk(EvWr, i - 2, int'(seq[i]));
         else if (i == seq.size() - 1 && i >= 2)
            e = (chk_flip == 8'd0) ? mk(EvOk, int'(cmd), len) : mk(EvErr, 2, 0);
         else has = 1'b0;
         send_byte(seq[i], pick_gap(gap), has, e);
      end
      if (stop >= 0) begin
         e     = mk(EvErr, 3, 0);
         e.cyc = last_cyc + 1 + longint'(TO);
         sb.push_back(e);
         repeat (TO + 2) @(negedge clk);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, expected finish within time limit");
      $fatal(1);
   end

   initial begin
      logic [7:0] pq[$];
      ev_t        none;
      none = mk(EvWr, 0, 0);
      bus.i_rx_done = 1'b0;
      bus.i_rx_data = 8'h00;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      pq = {8'h11, 8'h22};
      send_frame(8'h03, 2, pq, -1, 8'h00, 0);
      send_frame(8'h07, 0, noq, -1, 8'h00, 0);
      send_frame(8'h03, 2, pq, -1, 8'h01, 0);
      send_frame(8'h01, 17, noq, -1, 8'h00, 0);
      send_byte(8'h55, 0, 1'b0, none);
      send_frame(8'h09, 1, noq, -1, 8'h00, 0);
      pq = {8'hAA, 8'hBB};
      send_frame(8'h01, 2, pq, 3, 8'h00, 0);
      send_frame(8'h01, 2, pq, -1, 8'h00, int'(TO) - 1);

      send_byte(SYNC, 0, 1'b0, none);
      send_byte(8'h04, 0, 1'b0, none);
      send_byte(8'h05, 0, 1'b0, none);
      send_byte(8'h12, 0, 1'b1, mk(EvWr, 0, 8'h12));
      send_byte(8'h34, 0, 1'b1, mk(EvWr, 1, 8'h34));
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_zero_outputs("midreset");
      check("sb_empty_at_reset", sb.size(), 0);
      mon_cmd  = 0;
      mon_len  = 0;
      mon_code = 0;
      @(negedge clk);
      rst = 1'b0;
      send_frame(8'h0C, 3, noq, -1, 8'h00, 0);

      for (int f = 0; f < 80; f++) begin
         int         kind;
         int         len;
         logic [7:0] b;
         kind = $urandom_range(0, 9);
         len  = $urandom_range(0, MAX_LEN);
         if (kind <= 4) begin
            send_frame(8'($urandom), len, noq, -1, 8'h00, -1);
         end else if (kind == 5) begin
            send_frame(8'($urandom), len, noq, -1, 8'($urandom_range(1, 255)), -1);
         end else if (kind == 6) begin
            send_frame(8'($urandom), $urandom_range(MAX_LEN + 1, 255), noq, -1, 8'h00, -1);
         end else if (kind == 7) begin
            send_frame(8'($urandom), len, noq, $urandom_range(0, len + 2), 8'h00, -1);
         end else begin
            repeat ($urandom_range(1, 4)) begin
               b = 8'($urandom);
               if (b == SYNC) b = 8'h5A;
               send_byte(b, pick_gap(-1), 1'b0, none);
            end
            send_frame(8'($urandom), len, noq, -1, 8'h00, -1);
         end
      end

      repeat (TO + 5) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
